// File: rtl/scff_chain_ctrl.sv
// Scan-chain sequencer for scff cells: loads a word stream into the chain, reads it back
// by recirculating Q into SI, and clears it through the cells' active-low R pins.
module scff_chain_ctrl #(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 8
) (
    input  logic              clk,
    input  logic              R,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [WORD_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [WORD_W-1:0] rd_data,
    output logic              chain_e,
    output logic              chain_si,
    input  logic              chain_q,
    output logic              chain_ce,
    output logic              chain_r_n,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int BW     = $clog2(CHAIN_LEN + 1);
    localparam int SBW    = $clog2(WORD_W + 1);
    localparam int NWORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int WCW    = $clog2(NWORDS + 1);

    localparam logic [BW-1:0]  LEN_C      = BW'(CHAIN_LEN);
    localparam logic [BW-1:0]  LAST_BIT_C = BW'(CHAIN_LEN - 1);
    localparam logic [SBW-1:0] W_C        = SBW'(WORD_W);
    localparam logic [SBW-1:0] TAIL_C     = SBW'(CHAIN_LEN - (NWORDS - 1) * WORD_W);
    localparam logic [WCW-1:0] NWORDS_C   = WCW'(NWORDS);
    localparam logic [WCW-1:0] LASTW_C    = WCW'(NWORDS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READ  = 2'd2,
        CLEAR = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [BW-1:0]      bit_cnt;
    logic [WORD_W-1:0]  sreg;
    logic [SBW-1:0]     sbits;
    logic [WCW-1:0]     word_cnt;
    logic [WORD_W-1:0]  assy;
    logic [SBW-1:0]     abits;
    logic               rd_gap;
    logic               clr_cnt;
    logic               rd_valid_q;
    logic [WORD_W-1:0]  rd_data_q;
    logic               done_q;
    logic               err_q;

    logic cmd_acc, wr_acc, ld_shift, rd_shift, rd_xfer, rd_take, finish;

    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Chain-facing outputs depend only on registered state, so stalls on the word ports
    // can never reach chain_ce / chain_si / chain_e.
    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        wr_ready  = 1'b0;
        chain_e   = 1'b0;
        chain_ce  = 1'b1;
        chain_si  = 1'b0;
        chain_r_n = 1'b1;
        cmd_acc   = 1'b0;
        wr_acc    = 1'b0;
        ld_shift  = 1'b0;
        rd_shift  = 1'b0;
        rd_xfer   = 1'b0;
        rd_take   = 1'b0;
        finish    = 1'b0;
        unique case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    cmd_acc = 1'b1;
                    case (cmd_op)
                        2'b00:   state_d = LOAD;
                        2'b01:   state_d = READ;
                        2'b10:   state_d = CLEAR;
                        default: state_d = IDLE;
                    endcase
                end
            end
            LOAD: begin
                chain_e  = 1'b1;
                chain_si = sreg[0];
                ld_shift = (sbits != '0);
                chain_ce = ld_shift;
                wr_ready = (sbits == '0) && (word_cnt != NWORDS_C);
                wr_acc   = wr_ready && wr_valid;
                if (ld_shift && (bit_cnt == LAST_BIT_C)) begin
                    state_d = IDLE;
                    finish  = 1'b1;
                end
            end
            READ: begin
                chain_e  = 1'b1;
                chain_si = chain_q;
                rd_shift = !rd_valid_q && !rd_gap && (bit_cnt != LEN_C) && (abits != W_C);
                rd_xfer  = !rd_valid_q && !rd_gap && (abits != '0)
                           && ((abits == W_C) || (bit_cnt == LEN_C));
                rd_take  = rd_valid_q && rd_ready;
                chain_ce = rd_shift;
                if (rd_take && (bit_cnt == LEN_C)) begin
                    state_d = IDLE;
                    finish  = 1'b1;
                end
            end
            CLEAR: begin
                chain_r_n = 1'b0;
                if (clr_cnt) begin
                    state_d = IDLE;
                    finish  = 1'b1;
                end
            end
        endcase
    end

    // The final load word gets only the bits still missing from the chain; since every
    // word is accepted on a word boundary, that is a fixed tail length.
    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            bit_cnt    <= '0;
            sreg       <= '0;
            sbits      <= '0;
            word_cnt   <= '0;
            assy       <= '0;
            abits      <= '0;
            rd_gap     <= 1'b0;
            clr_cnt    <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q  <= finish;
            err_q   <= cmd_acc && (cmd_op == 2'b11);
            clr_cnt <= (state_q == CLEAR) && !clr_cnt;
            rd_gap  <= rd_take && !finish;
            if (cmd_acc) begin
                bit_cnt  <= '0;
                sbits    <= '0;
                word_cnt <= '0;
                assy     <= '0;
                abits    <= '0;
            end
            if (wr_acc) begin
                sreg     <= wr_data;
                sbits    <= (word_cnt == LASTW_C) ? TAIL_C : W_C;
                word_cnt <= word_cnt + 1'b1;
            end
            if (ld_shift) begin
                sreg    <= sreg >> 1;
                sbits   <= sbits - 1'b1;
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (rd_shift) begin
                for (int i = 0; i < WORD_W; i++) begin
                    if (abits == SBW'(i)) begin
                        assy[i] <= chain_q;
                    end
                end
                abits   <= abits + 1'b1;
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (rd_xfer) begin
                rd_data_q  <= assy;
                rd_valid_q <= 1'b1;
                assy       <= '0;
                abits      <= '0;
            end
            if (rd_take) begin
                rd_valid_q <= 1'b0;
            end
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign err      = err_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_scff_chain_ctrl.sv
// Bench for scff_chain_ctrl: two instances (64/8 and 12/8) each driving a behavioural
// scff chain; directed vectors with hand-computed expected words and cycle counts.
module tb_scff_chain_ctrl;
    localparam int BIG_LEN   = 64;
    localparam int SMALL_LEN = 12;
    localparam int WORD_W    = 8;
    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_BAD   = 2'b11;

    logic clk = 1'b0;
    logic R = 1'b0;
    logic sel = 1'b0;
    logic cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic wr_valid = 1'b0;
    logic [WORD_W-1:0] wr_data = '0;
    logic rd_ready = 1'b0;

    logic b_cmd_ready, b_wr_ready, b_rd_valid, b_chain_e, b_chain_si, b_chain_q;
    logic b_chain_ce, b_chain_r_n, b_busy, b_done, b_err;
    logic [WORD_W-1:0] b_rd_data;
    logic s_cmd_ready, s_wr_ready, s_rd_valid, s_chain_e, s_chain_si, s_chain_q;
    logic s_chain_ce, s_chain_r_n, s_busy, s_done, s_err;
    logic [WORD_W-1:0] s_rd_data;

    logic [BIG_LEN-1:0]   b_chain;
    logic [SMALL_LEN-1:0] s_chain;

    logic m_cmd_ready, m_wr_ready, m_rd_valid, m_chain_e, m_chain_si;
    logic m_chain_ce, m_chain_r_n, m_busy, m_done, m_err;
    logic [WORD_W-1:0] m_rd_data;

    int n_cmp = 0;
    int n_bad = 0;
    logic [WORD_W-1:0] ld_words [8];
    logic [WORD_W-1:0] exp_words [8];
    int ld_cycles, ld_shifts, ld_accepted, ld_done;
    int cmd_viol, stall_viol, rd_viol;
    logic [BIG_LEN-1:0] exp_chain;
    logic [BIG_LEN-1:0] snap;
    int done_during;

    always #5 clk = ~clk;

    scff_chain_ctrl #(.CHAIN_LEN(BIG_LEN), .WORD_W(WORD_W)) u_big (
        .clk(clk), .R(R),
        .cmd_valid(cmd_valid && !sel), .cmd_ready(b_cmd_ready), .cmd_op(cmd_op),
        .wr_valid(wr_valid), .wr_ready(b_wr_ready), .wr_data(wr_data),
        .rd_valid(b_rd_valid), .rd_ready(rd_ready), .rd_data(b_rd_data),
        .chain_e(b_chain_e), .chain_si(b_chain_si), .chain_q(b_chain_q),
        .chain_ce(b_chain_ce), .chain_r_n(b_chain_r_n),
        .busy(b_busy), .done(b_done), .err(b_err)
    );

    scff_chain_ctrl #(.CHAIN_LEN(SMALL_LEN), .WORD_W(WORD_W)) u_small (
        .clk(clk), .R(R),
        .cmd_valid(cmd_valid && sel), .cmd_ready(s_cmd_ready), .cmd_op(cmd_op),
        .wr_valid(wr_valid), .wr_ready(s_wr_ready), .wr_data(wr_data),
        .rd_valid(s_rd_valid), .rd_ready(rd_ready), .rd_data(s_rd_data),
        .chain_e(s_chain_e), .chain_si(s_chain_si), .chain_q(s_chain_q),
        .chain_ce(s_chain_ce), .chain_r_n(s_chain_r_n),
        .busy(s_busy), .done(s_done), .err(s_err)
    );

    // Behavioural scff chains: SI enters cell 0, Q of the last cell feeds back.
    always_ff @(posedge clk or negedge b_chain_r_n) begin
        if (!b_chain_r_n) b_chain <= '0;
        else if (b_chain_ce && b_chain_e) b_chain <= {b_chain[BIG_LEN-2:0], b_chain_si};
    end
    always_ff @(posedge clk or negedge s_chain_r_n) begin
        if (!s_chain_r_n) s_chain <= '0;
        else if (s_chain_ce && s_chain_e) s_chain <= {s_chain[SMALL_LEN-2:0], s_chain_si};
    end
    assign b_chain_q = b_chain[BIG_LEN-1];
    assign s_chain_q = s_chain[SMALL_LEN-1];

    assign m_cmd_ready = sel ? s_cmd_ready : b_cmd_ready;
    assign m_wr_ready  = sel ? s_wr_ready  : b_wr_ready;
    assign m_rd_valid  = sel ? s_rd_valid  : b_rd_valid;
    assign m_rd_data   = sel ? s_rd_data   : b_rd_data;
    assign m_chain_e   = sel ? s_chain_e   : b_chain_e;
    assign m_chain_si  = sel ? s_chain_si  : b_chain_si;
    assign m_chain_ce  = sel ? s_chain_ce  : b_chain_ce;
    assign m_chain_r_n = sel ? s_chain_r_n : b_chain_r_n;
    assign m_busy      = sel ? s_busy      : b_busy;
    assign m_done      = sel ? s_done      : b_done;
    assign m_err       = sel ? s_err       : b_err;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Presents a command for one edge; returns at the falling edge of the first new-state cycle.
    task automatic applyStimulus(input logic [1:0] op);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_cmd_ready"}, m_cmd_ready, 1);
        checkOutput({tag, "_wr_ready"},  m_wr_ready, 0);
        checkOutput({tag, "_rd_valid"},  m_rd_valid, 0);
        checkOutput({tag, "_rd_data"},   m_rd_data, 0);
        checkOutput({tag, "_chain_e"},   m_chain_e, 0);
        checkOutput({tag, "_chain_ce"},  m_chain_ce, 1);
        checkOutput({tag, "_chain_si"},  m_chain_si, 0);
        checkOutput({tag, "_chain_r_n"}, m_chain_r_n, 1);
        checkOutput({tag, "_busy"},      m_busy, 0);
        checkOutput({tag, "_done"},      m_done, 0);
        checkOutput({tag, "_err"},       m_err, 0);
    endtask

    // Offers ld_words[0..n_offer-1]; after each accepted word, wr_valid stays low for
    // `gap` cycles in which wr_ready is high. abort_at>0 leaves mid-load after that many
    // chain_ce cycles have been observed.
    task automatic loadWords(input int n_offer, input int gap, input bit hold_cmd,
                             input int abort_at);
        int idx;
        int gap_left;
        idx = 0; gap_left = 0;
        ld_cycles = 0; ld_shifts = 0; ld_accepted = 0; ld_done = 0;
        cmd_viol = 0; stall_viol = 0;
        applyStimulus(OP_LOAD);
        if (hold_cmd) begin
            cmd_valid = 1'b1;
            cmd_op    = OP_CLEAR;
        end
        for (int cyc = 1; cyc <= 3000; cyc++) begin
            if (m_done) begin
                ld_done = 1; ld_cycles = cyc;
                break;
            end
            if (hold_cmd && m_cmd_ready) cmd_viol++;
            if (m_chain_ce) ld_shifts++;
            if (abort_at != 0 && ld_shifts == abort_at) begin
                wr_valid = 1'b0; cmd_valid = 1'b0;
                return;
            end
            if (idx < n_offer && gap_left == 0) begin
                wr_valid = 1'b1;
                wr_data  = ld_words[idx];
            end else begin
                wr_valid = 1'b0;
            end
            if (m_wr_ready && !wr_valid && m_chain_ce) stall_viol++;
            if (m_wr_ready) begin
                if (wr_valid) begin
                    idx++; ld_accepted++; gap_left = gap;
                end else if (gap_left > 0) begin
                    gap_left--;
                end
            end
            @(negedge clk);
        end
        wr_valid  = 1'b0;
        cmd_valid = 1'b0;
        checkOutput("load_done_seen", ld_done, 1);
    endtask

    // Takes n_words read words, holding rd_ready low for `stall` cycles per word.
    task automatic readWords(input int n_words, input int stall, input string tag);
        int got, wait_cnt, seen_done;
        bit gap_next;
        got = 0; wait_cnt = 0; seen_done = 0; gap_next = 1'b0; rd_viol = 0;
        applyStimulus(OP_READ);
        for (int cyc = 1; cyc <= 5000; cyc++) begin
            if (m_done) begin
                seen_done = 1;
                break;
            end
            if (gap_next && m_chain_ce) rd_viol++;
            gap_next = 1'b0;
            if (m_rd_valid && m_chain_ce) rd_viol++;
            rd_ready = 1'b0;
            if (m_rd_valid) begin
                if (wait_cnt >= stall) begin
                    rd_ready = 1'b1;
                    if (got < n_words)
                        checkOutput($sformatf("%s_word%0d", tag, got), m_rd_data, exp_words[got]);
                    got++; wait_cnt = 0; gap_next = 1'b1;
                end else begin
                    wait_cnt++;
                end
            end
            @(negedge clk);
        end
        rd_ready = 1'b0;
        checkOutput({tag, "_word_count"}, got, n_words);
        checkOutput({tag, "_done_seen"}, seen_done, 1);
        checkOutput({tag, "_stall_ce"}, rd_viol, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        R = 1'b0;
        repeat (3) @(negedge clk);
        checkResetValues("rst");
        R = 1'b1;

        // Contiguous load of 0x01..0x08: 72 load cycles, done in cycle 73.
        for (int i = 0; i < 8; i++) begin
            ld_words[i]  = 8'(i + 1);
            exp_words[i] = 8'(i + 1);
        end
        loadWords(8, 0, 1'b0, 0);
        checkOutput("load_cycles", ld_cycles, 73);
        checkOutput("load_shifts", ld_shifts, 64);
        checkOutput("load_words", ld_accepted, 8);
        for (int j = 0; j < BIG_LEN; j++) exp_chain[BIG_LEN-1-j] = ld_words[j/8][j%8];
        checkOutput("load_chain_lo", b_chain[31:0], exp_chain[31:0]);
        checkOutput("load_chain_hi", b_chain[63:32], exp_chain[63:32]);
        readWords(8, 0, "rd1");
        readWords(8, 0, "rd2");

        // Illegal op: one err pulse, stays idle, chain untouched.
        snap = b_chain;
        applyStimulus(OP_BAD);
        checkOutput("bad_err", m_err, 1);
        checkOutput("bad_busy", m_busy, 0);
        checkOutput("bad_cmd_ready", m_cmd_ready, 1);
        checkOutput("bad_chain_e", m_chain_e, 0);
        @(negedge clk);
        checkOutput("bad_err_off", m_err, 0);
        checkOutput("bad_busy2", m_busy, 0);
        checkOutput("bad_chain_kept", (b_chain == snap), 1);

        // Stalled load with a CLEAR held on cmd_valid the whole time, then stalled read.
        ld_words = '{8'h5A, 8'hC3, 8'h0F, 8'h96, 8'h71, 8'hE8, 8'h24, 8'hBD};
        exp_words = ld_words;
        loadWords(8, 5, 1'b1, 0);
        checkOutput("gap_shifts", ld_shifts, 64);
        checkOutput("gap_words", ld_accepted, 8);
        checkOutput("gap_stall_ce", stall_viol, 0);
        checkOutput("gap_cmd_ready", cmd_viol, 0);
        readWords(8, 10, "rdstall");

        // All ones, then CLEAR: two cycles of chain_r_n low, done in the third.
        for (int i = 0; i < 8; i++) ld_words[i] = 8'hFF;
        loadWords(8, 0, 1'b0, 0);
        applyStimulus(OP_CLEAR);
        checkOutput("clr_r_n_c1", m_chain_r_n, 0);
        checkOutput("clr_e_c1", m_chain_e, 0);
        checkOutput("clr_busy_c1", m_busy, 1);
        @(negedge clk);
        checkOutput("clr_r_n_c2", m_chain_r_n, 0);
        checkOutput("clr_done_c2", m_done, 0);
        @(negedge clk);
        checkOutput("clr_r_n_c3", m_chain_r_n, 1);
        checkOutput("clr_done_c3", m_done, 1);
        checkOutput("clr_busy_c3", m_busy, 0);
        for (int i = 0; i < 8; i++) exp_words[i] = 8'h00;
        readWords(8, 0, "rdclr");

        // Reset asserted mid-load after 20 shifts.
        for (int i = 0; i < 8; i++) ld_words[i] = 8'((i + 1) * 8'h11);
        loadWords(8, 0, 1'b0, 20);
        @(posedge clk);
        #2 R = 1'b0;
        #1 checkResetValues("midrst");
        done_during = 0;
        repeat (3) begin
            @(negedge clk);
            if (m_done) done_during = 1;
        end
        R = 1'b1;
        @(negedge clk);
        if (m_done) done_during = 1;
        checkOutput("midrst_no_done", done_during, 0);
        ld_words = '{8'hC1, 8'h7E, 8'h00, 8'hFF, 8'h80, 8'h01, 8'h3C, 8'hA9};
        exp_words = ld_words;
        loadWords(8, 0, 1'b0, 0);
        checkOutput("post_rst_cycles", ld_cycles, 73);
        readWords(8, 0, "rdpost");

        // 12-cell chain: the second word is cut to 4 bits, the third is never accepted.
        sel = 1'b1;
        @(negedge clk);
        ld_words[0] = 8'hA5;
        ld_words[1] = 8'hF3;
        ld_words[2] = 8'h77;
        loadWords(3, 0, 1'b0, 0);
        checkOutput("sm_cycles", ld_cycles, 15);
        checkOutput("sm_shifts", ld_shifts, 12);
        checkOutput("sm_words", ld_accepted, 2);
        exp_words[0] = 8'hA5;
        exp_words[1] = 8'h03;
        readWords(2, 0, "rdsm");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
